// File: rtl/contador_pkg.sv
// Shared encodings and defaults for the generic up/down counter.
// Used by contador_generico and contador_generico_prox.
package contador_pkg;

  localparam logic MODO_WRAP = 1'b0;
  localparam logic MODO_SAT  = 1'b1;

  localparam int unsigned RESET_VAL_DEF = 32'd106;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'b00,
    DIR_DOWN = 2'b01,
    DIR_UP   = 2'b10,
    DIR_BOTH = 2'b11
  } direcao_e;

endpackage

// File: rtl/contador_generico_chk.sv
// Simulation checker: flags an illegal step size whenever it is actually used.
module contador_generico_chk #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] MIN_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input logic             clk,
  input logic             rst,
  input logic             habilitar,
  input logic             acrescer,
  input logic             decrecer,
  input logic             carregar,
  input logic [WIDTH-1:0] passo
);

  localparam logic [WIDTH-1:0] PASSO_MAX = MAX_VAL - MIN_VAL;

  a_passo_legal: assert property (@(posedge clk) disable iff (rst)
    (!carregar && habilitar && (acrescer != decrecer)) |-> (passo <= PASSO_MAX));

endmodule

// File: rtl/contador_generico_prox.sv
// Next-value logic: load clamp, step, range reduction/saturation and overflow flag.
// Saturation is built only when CONTADOR_GENERICO_SAT_EN is defined.
module contador_generico_prox
  import contador_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] MIN_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0] saida,
  input  logic             habilitar,
  input  logic             acrescer,
  input  logic             decrecer,
  input  logic [WIDTH-1:0] passo,
  input  logic             modo_sat,
  input  logic             carregar,
  input  logic [WIDTH-1:0] valor_carga,
  output logic [WIDTH-1:0] prox_val,
  output logic             prox_ovf
);

  localparam logic [WIDTH:0] MIN_EXT   = {1'b0, MIN_VAL};
  localparam logic [WIDTH:0] MAX_EXT   = {1'b0, MAX_VAL};
  localparam logic [WIDTH:0] RANGE_EXT = MAX_EXT - MIN_EXT + {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] saida_ext_s;
  logic [WIDTH:0] passo_ext_s;
  logic [WIDTH:0] carga_ext_s;
  logic [WIDTH:0] folga_sup_s;
  logic [WIDTH:0] folga_inf_s;
  logic [WIDTH:0] soma_s;
  logic [WIDTH:0] dif_s;
  logic [WIDTH:0] wrap_up_s;
  logic [WIDTH:0] wrap_dn_s;
  logic [WIDTH:0] prox_ext_s;
  logic           sat_s;
  direcao_e       dir_s;
  logic           unused_msb_s;

  assign dir_s = direcao_e'({acrescer, decrecer});

  // One extra bit keeps every intermediate free of a modulo-2**WIDTH wrap.
  always_comb begin
    saida_ext_s = {1'b0, saida};
    passo_ext_s = {1'b0, passo};
    carga_ext_s = {1'b0, valor_carga};
    folga_sup_s = MAX_EXT - saida_ext_s;
    folga_inf_s = saida_ext_s - MIN_EXT;
    soma_s      = saida_ext_s + passo_ext_s;
    dif_s       = saida_ext_s - passo_ext_s;
    wrap_up_s   = soma_s - RANGE_EXT;
    wrap_dn_s   = saida_ext_s + RANGE_EXT - passo_ext_s;
  end

`ifdef CONTADOR_GENERICO_SAT_EN
  assign sat_s = (modo_sat == MODO_SAT);
`else
  logic unused_modo_s;
  assign unused_modo_s = modo_sat;
  assign sat_s         = MODO_WRAP;
`endif

  // Priority: load, then a single-direction step; anything else holds.
  always_comb begin
    prox_ext_s = saida_ext_s;
    prox_ovf   = 1'b0;
    if (carregar) begin
      if (carga_ext_s < MIN_EXT) begin
        prox_ext_s = MIN_EXT;
      end else if (carga_ext_s > MAX_EXT) begin
        prox_ext_s = MAX_EXT;
      end else begin
        prox_ext_s = carga_ext_s;
      end
    end else if (habilitar && (passo != {WIDTH{1'b0}})) begin
      case (dir_s)
        DIR_UP: begin
          if (passo_ext_s > folga_sup_s) begin
            prox_ovf = 1'b1;
`ifdef CONTADOR_GENERICO_SAT_EN
            if (sat_s) begin
              prox_ext_s = MAX_EXT;
            end else begin
              prox_ext_s = wrap_up_s;
            end
`else
            prox_ext_s = wrap_up_s;
`endif
          end else begin
            prox_ext_s = soma_s;
          end
        end
        DIR_DOWN: begin
          if (passo_ext_s > folga_inf_s) begin
            prox_ovf = 1'b1;
`ifdef CONTADOR_GENERICO_SAT_EN
            if (sat_s) begin
              prox_ext_s = MIN_EXT;
            end else begin
              prox_ext_s = wrap_dn_s;
            end
`else
            prox_ext_s = wrap_dn_s;
`endif
          end else begin
            prox_ext_s = dif_s;
          end
        end
        default: begin
          prox_ext_s = saida_ext_s;
          prox_ovf   = 1'b0;
        end
      endcase
    end else begin
      prox_ext_s = saida_ext_s;
      prox_ovf   = 1'b0;
    end
  end

  assign prox_val     = prox_ext_s[WIDTH-1:0];
  assign unused_msb_s = prox_ext_s[WIDTH] ^ sat_s;

endmodule

// File: rtl/contador_generico.sv
// Generic bounded up/down counter with wrap or (CONTADOR_GENERICO_SAT_EN) saturate.
// Holds the count and overflow-pulse registers; next-state math is in _prox.
module contador_generico
  import contador_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] MIN_VAL   = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VAL_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             habilitar,
  input  logic             acrescer,
  input  logic             decrecer,
  input  logic [WIDTH-1:0] passo,
  input  logic             modo_sat,
  input  logic             carregar,
  input  logic [WIDTH-1:0] valor_carga,
  output logic [WIDTH-1:0] saida,
  output logic             no_max,
  output logic             no_min,
  output logic             transbordo
);

  logic [WIDTH-1:0] saida_r;
  logic             transbordo_r;
  logic [WIDTH-1:0] prox_val_s;
  logic             prox_ovf_s;

  contador_generico_prox #(
    .WIDTH  (WIDTH),
    .MIN_VAL(MIN_VAL),
    .MAX_VAL(MAX_VAL)
  ) u_prox (
    .saida      (saida_r),
    .habilitar  (habilitar),
    .acrescer   (acrescer),
    .decrecer   (decrecer),
    .passo      (passo),
    .modo_sat   (modo_sat),
    .carregar   (carregar),
    .valor_carga(valor_carga),
    .prox_val   (prox_val_s),
    .prox_ovf   (prox_ovf_s)
  );

  contador_generico_chk #(
    .WIDTH  (WIDTH),
    .MIN_VAL(MIN_VAL),
    .MAX_VAL(MAX_VAL)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .habilitar(habilitar),
    .acrescer (acrescer),
    .decrecer (decrecer),
    .carregar (carregar),
    .passo    (passo)
  );

  // Count and overflow-pulse registers; reset discards any pending update.
  always_ff @(posedge clk) begin
    if (rst) begin
      saida_r      <= RESET_VAL;
      transbordo_r <= 1'b0;
    end else begin
      saida_r      <= prox_val_s;
      transbordo_r <= prox_ovf_s;
    end
  end

  assign saida      = saida_r;
  assign transbordo = transbordo_r;
  assign no_max     = (saida_r == MAX_VAL);
  assign no_min     = (saida_r == MIN_VAL);

endmodule

// File: tb/tb_contador_generico.sv
// Scoreboard bench for contador_generico: default instance (0..255) and a 10..20 instance.
module tb_contador_generico;

`ifdef CONTADOR_GENERICO_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_hab, a_acr, a_dec, a_ms, a_car, a_max, a_min, a_tr;
  logic [7:0] a_passo, a_vc, a_saida;
  logic       b_rst, b_hab, b_acr, b_dec, b_ms, b_car, b_max, b_min, b_tr;
  logic [7:0] b_passo, b_vc, b_saida;

  contador_generico dut_a (
    .clk(clk), .rst(a_rst), .habilitar(a_hab), .acrescer(a_acr), .decrecer(a_dec),
    .passo(a_passo), .modo_sat(a_ms), .carregar(a_car), .valor_carga(a_vc),
    .saida(a_saida), .no_max(a_max), .no_min(a_min), .transbordo(a_tr)
  );

  contador_generico #(
    .WIDTH(8), .MIN_VAL(8'd10), .MAX_VAL(8'd20), .RESET_VAL(8'd15)
  ) dut_b (
    .clk(clk), .rst(b_rst), .habilitar(b_hab), .acrescer(b_acr), .decrecer(b_dec),
    .passo(b_passo), .modo_sat(b_ms), .carregar(b_car), .valor_carga(b_vc),
    .saida(b_saida), .no_max(b_max), .no_min(b_min), .transbordo(b_tr)
  );

  typedef struct {
    bit         sel;
    logic [7:0] s;
    logic       t;
    logic       mx;
    logic       mn;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic cmp(input string nm, input string fld, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s.%s got=%0d want=%0d", nm, fld, got, want);
    end
  endtask

  // Monitor: outputs are stable at the falling edge; pop and compare.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      if (mon_e.sel) begin
        cmp(mon_e.nm, "saida", b_saida, mon_e.s);
        cmp(mon_e.nm, "transbordo", {7'd0, b_tr}, {7'd0, mon_e.t});
        cmp(mon_e.nm, "no_max", {7'd0, b_max}, {7'd0, mon_e.mx});
        cmp(mon_e.nm, "no_min", {7'd0, b_min}, {7'd0, mon_e.mn});
      end else begin
        cmp(mon_e.nm, "saida", a_saida, mon_e.s);
        cmp(mon_e.nm, "transbordo", {7'd0, a_tr}, {7'd0, mon_e.t});
        cmp(mon_e.nm, "no_max", {7'd0, a_max}, {7'd0, mon_e.mx});
        cmp(mon_e.nm, "no_min", {7'd0, a_min}, {7'd0, mon_e.mn});
      end
    end
  end

  // sel=0 drives dut_a (0..255), sel=1 drives dut_b (10..20); the other idles.
  task automatic step(input bit sel, input logic r, c, h, ac, dc, ms,
                      input logic [7:0] p, vc, es, input logic et, input string nm);
    exp_t e;
    @(negedge clk);
    a_rst = 1'b0; a_car = 1'b0; a_hab = 1'b0; a_acr = 1'b0; a_dec = 1'b0;
    b_rst = 1'b0; b_car = 1'b0; b_hab = 1'b0; b_acr = 1'b0; b_dec = 1'b0;
    if (sel) begin
      b_rst = r; b_car = c; b_hab = h; b_acr = ac; b_dec = dc; b_ms = ms; b_passo = p; b_vc = vc;
    end else begin
      a_rst = r; a_car = c; a_hab = h; a_acr = ac; a_dec = dc; a_ms = ms; a_passo = p; a_vc = vc;
    end
    @(posedge clk);
    #1;
    e.sel = sel; e.s = es; e.t = et; e.nm = nm;
    e.mx  = sel ? (es == 8'd20) : (es == 8'd255);
    e.mn  = sel ? (es == 8'd10) : (es == 8'd0);
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    a_rst = 1'b1; a_car = 1'b0; a_hab = 1'b0; a_acr = 1'b0; a_dec = 1'b0; a_ms = 1'b0;
    a_passo = 8'd0; a_vc = 8'd0;
    b_rst = 1'b1; b_car = 1'b0; b_hab = 1'b0; b_acr = 1'b0; b_dec = 1'b0; b_ms = 1'b0;
    b_passo = 8'd0; b_vc = 8'd0;

    //       sel r c h a d ms passo vc      exp_saida           exp_tr
    step(0, 1, 0, 0, 0, 0, 0, 8'd0,  8'd0,   8'd106,             1'b0, "a_reset");
    step(0, 0, 0, 1, 1, 0, 0, 8'd1,  8'd0,   8'd107,             1'b0, "a_inc1");
    step(0, 0, 0, 1, 1, 0, 0, 8'd1,  8'd0,   8'd108,             1'b0, "a_inc2");
    step(0, 0, 0, 1, 1, 0, 0, 8'd1,  8'd0,   8'd109,             1'b0, "a_inc3");
    step(0, 0, 1, 0, 0, 0, 0, 8'd0,  8'd250, 8'd250,             1'b0, "a_load250");
    step(0, 0, 0, 1, 1, 0, 0, 8'd10, 8'd0,   8'd4,               1'b1, "a_wrap_up");
    step(0, 0, 0, 0, 1, 0, 0, 8'd10, 8'd0,   8'd4,               1'b0, "a_hab0_hold");
    step(0, 0, 1, 0, 0, 0, 0, 8'd0,  8'd250, 8'd250,             1'b0, "a_reload250");
    step(0, 0, 0, 1, 1, 0, 1, 8'd10, 8'd0,   SAT ? 8'd255 : 8'd4,  1'b1, "a_sat_up");
    step(0, 0, 0, 1, 1, 0, 1, 8'd10, 8'd0,   SAT ? 8'd255 : 8'd14, SAT, "a_sat_up_again");
    step(0, 0, 1, 0, 0, 0, 0, 8'd0,  8'd50,  8'd50,              1'b0, "a_load50");
    step(0, 0, 0, 1, 1, 1, 0, 8'd5,  8'd0,   8'd50,              1'b0, "a_both_hold");
    step(0, 0, 0, 0, 1, 0, 0, 8'd5,  8'd0,   8'd50,              1'b0, "a_dis_hold");
    step(0, 0, 0, 1, 0, 1, 0, 8'd5,  8'd0,   8'd45,              1'b0, "a_dec5");
    step(0, 0, 1, 0, 0, 0, 0, 8'd0,  8'd2,   8'd2,               1'b0, "a_load2");
    step(0, 0, 0, 1, 0, 1, 0, 8'd5,  8'd0,   8'd253,             1'b1, "a_wrap_dn");
    step(0, 0, 1, 0, 0, 0, 0, 8'd0,  8'd0,   8'd0,               1'b0, "a_load0");
    step(0, 0, 0, 1, 1, 0, 0, 8'd0,  8'd0,   8'd0,               1'b0, "a_passo0");
    step(0, 0, 1, 0, 0, 0, 0, 8'd0,  8'd255, 8'd255,             1'b0, "a_load255");
    step(0, 0, 0, 1, 1, 0, 0, 8'd1,  8'd0,   8'd0,               1'b1, "a_max_plus1");
    step(0, 1, 0, 1, 1, 0, 0, 8'd1,  8'd0,   8'd106,             1'b0, "a_rst_midcount");
    step(0, 0, 0, 1, 1, 0, 0, 8'd1,  8'd0,   8'd107,             1'b0, "a_resume");
    step(0, 1, 1, 0, 0, 0, 0, 8'd0,  8'd7,   8'd106,             1'b0, "a_rst_over_load");
    step(0, 0, 0, 1, 1, 0, 0, 8'd1,  8'd0,   8'd107,             1'b0, "a_after_rst");
    step(0, 0, 1, 0, 0, 0, 0, 8'd0,  8'd3,   8'd3,               1'b0, "a_load3");
    step(0, 0, 0, 1, 0, 1, 1, 8'd5,  8'd0,   SAT ? 8'd0 : 8'd254,  1'b1, "a_sat_dn");
    step(0, 0, 0, 1, 0, 1, 1, 8'd5,  8'd0,   SAT ? 8'd0 : 8'd249,  SAT, "a_sat_dn_again");
    step(0, 0, 0, 1, 0, 1, 0, 8'd5,  8'd0,   SAT ? 8'd251 : 8'd244, SAT, "a_mode_switch");

    step(1, 1, 0, 0, 0, 0, 0, 8'd0,  8'd0,   8'd15,              1'b0, "b_reset");
    step(1, 0, 1, 0, 0, 0, 0, 8'd0,  8'd25,  8'd20,              1'b0, "b_load_clamp_hi");
    step(1, 0, 1, 0, 0, 0, 0, 8'd0,  8'd5,   8'd10,              1'b0, "b_load_clamp_lo");
    step(1, 0, 1, 0, 0, 0, 0, 8'd0,  8'd12,  8'd12,              1'b0, "b_load12");
    step(1, 0, 0, 1, 0, 1, 0, 8'd5,  8'd0,   8'd18,              1'b1, "b_wrap_dn");
    step(1, 0, 0, 0, 0, 1, 0, 8'd5,  8'd0,   8'd18,              1'b0, "b_pulse_clear");
    step(1, 0, 0, 1, 1, 0, 0, 8'd5,  8'd0,   8'd12,              1'b1, "b_wrap_up5");
    step(1, 0, 0, 1, 1, 0, 0, 8'd10, 8'd0,   8'd11,              1'b1, "b_wrap_up10");
    step(1, 0, 0, 1, 0, 1, 0, 8'd10, 8'd0,   8'd12,              1'b1, "b_wrap_dn10");
    step(1, 0, 0, 1, 1, 0, 0, 8'd8,  8'd0,   8'd20,              1'b0, "b_exact_max");
    step(1, 0, 0, 1, 1, 0, 1, 8'd10, 8'd0,   SAT ? 8'd20 : 8'd19,  1'b1, "b_sat_up");
    step(1, 0, 0, 1, 0, 1, 1, 8'd10, 8'd0,   SAT ? 8'd10 : 8'd20,  !SAT, "b_dn10_mode");

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/contador_generico.md
CONTADOR_GENERICO -- requirements
Module: contador_generico

Interface
REQ-001 Parameter WIDTH, 8, counter and load-value width in bits; SHALL be 2..32.
REQ-002 Parameter MIN_VAL, 0, lowest legal count; SHALL satisfy MIN_VAL < MAX_VAL.
REQ-003 Parameter MAX_VAL, 2**WIDTH-1, highest legal count; SHALL fit in WIDTH bits.
REQ-004 Parameter RESET_VAL, 106, count after reset; SHALL satisfy MIN_VAL <= RESET_VAL <= MAX_VAL.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 habilitar  input  1  count enable; gates acrescer/decrecer only, not carregar.
REQ-008 acrescer  input  1  request increment by passo.
REQ-009 decrecer  input  1  request decrement by passo.
REQ-010 passo  input  WIDTH  step size; legal range 0..(MAX_VAL-MIN_VAL).
REQ-011 modo_sat  input  1  1 = saturate at bounds, 0 = wrap within [MIN_VAL, MAX_VAL].
REQ-012 carregar  input  1  synchronous load of valor_carga.
REQ-013 valor_carga  input  WIDTH  load value.
REQ-014 saida  output  WIDTH  registered count.
REQ-015 no_max / no_min  output  1 each  combinational: saida == MAX_VAL / saida == MIN_VAL.
REQ-016 transbordo  output  1  registered one-cycle pulse marking a wrap or saturation event.

Function
REQ-017 Priority per edge: rst, then carregar, then counting; counting only when habilitar=1.
REQ-018 carregar=1 SHALL set saida to valor_carga clamped into [MIN_VAL, MAX_VAL]; transbordo=0 next cycle.
REQ-019 habilitar=1, acrescer=1, decrecer=0: target = saida + passo; decrecer=1, acrescer=0: target = saida - passo.
REQ-020 Both or neither of acrescer/decrecer, habilitar=0, or passo=0 SHALL hold saida and give transbordo=0.
REQ-021 Arithmetic SHALL use WIDTH+1-bit intermediates; no silent modulo-2**WIDTH wrap.
REQ-022 Wrap mode: out-of-range target SHALL reduce modulo R = MAX_VAL-MIN_VAL+1 into range, e.g. MAX_VAL+k becomes MIN_VAL+k-1.
REQ-023 Saturate mode: out-of-range target SHALL clamp to MAX_VAL (up) or MIN_VAL (down).
REQ-024 transbordo SHALL be 1 for exactly the cycle after any update whose target left the range, in either mode, including saturation while already at a bound.
REQ-025 A modo_sat change SHALL take effect on the same edge it is sampled.
REQ-026 A passo value > MAX_VAL-MIN_VAL is illegal; a simulation-only assertion SHALL flag it when used.

Reset
REQ-027 While rst=1 at a rising edge, saida SHALL become RESET_VAL and transbordo 0, overriding all other inputs.
REQ-028 Reset asserted mid-count SHALL discard the pending update; counting SHALL resume on the first edge after rst falls.

Configuration
REQ-029 Macro CONTADOR_GENERICO_SAT_EN defined: saturate logic is built and modo_sat is honoured.
REQ-030 Macro not defined: modo_sat is present but ignored, the block always wraps, and no clamp logic is synthesised.

Structure
REQ-031 Package contador_pkg SHALL hold the modo_sat encodings (MODO_WRAP=0, MODO_SAT=1) and the default RESET_VAL constant (106).
REQ-032 Combinational next-value calculation (target, range reduction, clamp, overflow flag) SHALL live in sub-module contador_generico_prox; the top holds the registers only.

Verification
REQ-033 Defaults, rst=1 for 1 edge -> saida=106, transbordo=0; then acrescer, passo=1, 3 edges -> saida=109.
REQ-034 Defaults, load 250, wrap, acrescer, passo=10 -> saida=4, transbordo=1 for one cycle, then 0.
REQ-035 Macro on, load 250, modo_sat=1, acrescer, passo=10 -> saida=255, no_max=1, transbordo pulse; repeat -> saida=255, pulse again.
REQ-036 MIN_VAL=10, MAX_VAL=20: load 25 -> saida=20; load 12, wrap, decrecer, passo=5 -> saida=18, transbordo pulse.
REQ-037 acrescer=decrecer=1 at saida=50 -> saida=50; habilitar=0 with acrescer -> hold; carregar with habilitar=0 -> load applied.
REQ-038 rst=1 on the same edge as carregar=1, valor_carga=7 -> saida=106; next edge with acrescer, passo=1 -> saida=107.
